// File: rtl/multicycle_ctrl_pkg.sv
// Shared RV32I control definitions: opcodes, FSM states, immediate formats, decoded control word.
// Used by the controller, its decoder and the immediate generator.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_sel_t;

    typedef struct packed {
        imm_sel_t   imm_sel;
        logic       legal;
        logic       is_mem;
        logic       is_store;
        logic       is_branch;
        logic       is_jump;
        logic       rf_we;
        logic       alu_a_sel;  // 1 = PC
        logic       alu_b_sel;  // 1 = immediate
        logic [1:0] wb_sel;
    } ctrl_t;

    // funct3 picks which ALU compare flag decides the branch
    function automatic logic br_taken(input logic [2:0] f3, input logic eq,
                                      input logic lt, input logic ltu);
        case (f3)
            3'b000:  return eq;
            3'b001:  return !eq;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory request-acknowledge handshake between the controller and memory.
// Requests are held until the matching ack strobe; acks are single-cycle.
interface multicycle_ctrl_if;
    logic o_imem_req;
    logic i_imem_ack;
    logic o_dmem_req;
    logic o_dmem_we;
    logic i_dmem_ack;

    modport master (output o_imem_req, o_dmem_req, o_dmem_we,
                    input  i_imem_ack, i_dmem_ack);
    modport slave  (input  o_imem_req, o_dmem_req, o_dmem_we,
                    output i_imem_ack, i_dmem_ack);
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode-to-control decode; zero latency, no handshake.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl         = '0;
        ctrl.imm_sel = IMM_NONE;
        ctrl.legal   = 1'b1;
        ctrl.wb_sel  = WB_ALU;
        case (opcode)
            OPC_LOAD: begin
                ctrl.imm_sel   = IMM_I;
                ctrl.is_mem    = 1'b1;
                ctrl.rf_we     = 1'b1;
                ctrl.alu_b_sel = 1'b1;
                ctrl.wb_sel    = WB_MEM;
            end
            OPC_STORE: begin
                ctrl.imm_sel   = IMM_S;
                ctrl.is_mem    = 1'b1;
                ctrl.is_store  = 1'b1;
                ctrl.alu_b_sel = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.imm_sel   = IMM_B;
                ctrl.is_branch = 1'b1;
            end
            OPC_JAL: begin
                ctrl.imm_sel   = IMM_J;
                ctrl.is_jump   = 1'b1;
                ctrl.rf_we     = 1'b1;
                ctrl.alu_a_sel = 1'b1;
                ctrl.alu_b_sel = 1'b1;
                ctrl.wb_sel    = WB_PC4;
            end
            OPC_JALR: begin
                ctrl.imm_sel   = IMM_I;
                ctrl.is_jump   = 1'b1;
                ctrl.rf_we     = 1'b1;
                ctrl.alu_b_sel = 1'b1;
                ctrl.wb_sel    = WB_PC4;
            end
            OPC_OPIMM: begin
                ctrl.imm_sel   = IMM_I;
                ctrl.rf_we     = 1'b1;
                ctrl.alu_b_sel = 1'b1;
            end
            OPC_OP: begin
                ctrl.rf_we     = 1'b1;
            end
            OPC_LUI: begin
                ctrl.imm_sel   = IMM_U;
                ctrl.rf_we     = 1'b1;
                ctrl.alu_b_sel = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.imm_sel   = IMM_U;
                ctrl.rf_we     = 1'b1;
                ctrl.alu_a_sel = 1'b1;
                ctrl.alu_b_sel = 1'b1;
            end
            default: ctrl.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with memory-wait timeout; 4 cycles/instr, 5 for LOAD/STORE, more while acks are late.
// Memory requests are held until ack or timeout; define RV32I_ILLEGAL_TRAP_EN to trap on unknown opcodes.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [31:0]           i_inst,
    input  logic                  i_alu_eq,
    input  logic                  i_alu_lt,
    input  logic                  i_alu_ltu,
    multicycle_ctrl_if.master     mem,
    output logic                  o_ir_we,
    output logic                  o_pc_we,
    output logic                  o_rf_we,
    output imm_sel_t              o_imm_sel,
    output logic                  o_pc_sel,
    output logic                  o_alu_a_sel,
    output logic                  o_alu_b_sel,
    output logic [1:0]            o_wb_sel,
    output state_t                o_state,
    output logic                  o_retire,
`ifdef RV32I_ILLEGAL_TRAP_EN
    output logic                  o_illegal,
`endif
    output logic                  o_bus_err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t          state, state_nxt;
    ctrl_t           ctrl;
    logic [CW-1:0]   wait_cnt;
    logic            err_q;
    logic            waiting, ack, got, timeout, taken;
    logic            unused_inst;

    ctrl_decode u_decode (
        .opcode (i_inst[6:0]),
        .ctrl   (ctrl)
    );

    assign taken       = br_taken(i_inst[14:12], i_alu_eq, i_alu_lt, i_alu_ltu);
    assign unused_inst = ^{i_inst[31:15], i_inst[11:7]};
    assign o_state     = state;

    // The cycle after a bus error is a dead FETCH cycle so the abandoned request is visibly dropped
    always_comb begin
        waiting = 1'b0;
        ack     = 1'b0;
        case (state)
            ST_FETCH: begin
                waiting = !err_q;
                ack     = mem.i_imem_ack;
            end
            ST_MEM: begin
                waiting = 1'b1;
                ack     = mem.i_dmem_ack;
            end
            default: ;
        endcase
    end

    assign got     = waiting && ack;
    assign timeout = waiting && !ack && (wait_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= ST_FETCH;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout;
            if (got || timeout || !waiting || (state_nxt != state)) wait_cnt <= '0;
            else                                                   wait_cnt <= wait_cnt + CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  if (got) state_nxt = ST_DECODE;
`ifdef RV32I_ILLEGAL_TRAP_EN
            ST_DECODE: state_nxt = ctrl.legal ? ST_EXEC : ST_TRAP;
            ST_TRAP:   state_nxt = ST_TRAP;
`else
            ST_DECODE: state_nxt = ST_EXEC;
`endif
            ST_EXEC:   state_nxt = ctrl.is_mem ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (got)          state_nxt = ST_WB;
                else if (timeout) state_nxt = ST_FETCH;
            end
            ST_WB:     state_nxt = ST_FETCH;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    // Everything is quiet while reset is held, whatever the state register says
    always_comb begin
        mem.o_imem_req = 1'b0;
        mem.o_dmem_req = 1'b0;
        mem.o_dmem_we  = 1'b0;
        o_ir_we        = 1'b0;
        o_pc_we        = 1'b0;
        o_rf_we        = 1'b0;
        o_imm_sel      = IMM_NONE;
        o_pc_sel       = 1'b0;
        o_alu_a_sel    = 1'b0;
        o_alu_b_sel    = 1'b0;
        o_wb_sel       = WB_ALU;
        o_retire       = 1'b0;
        o_bus_err      = 1'b0;
`ifdef RV32I_ILLEGAL_TRAP_EN
        o_illegal      = 1'b0;
`endif
        if (i_rst_n) begin
            o_bus_err = timeout;
            case (state)
                ST_FETCH: begin
                    mem.o_imem_req = !err_q;
                    o_ir_we        = got;
                end
                ST_DECODE, ST_EXEC, ST_MEM, ST_WB: begin
                    o_imm_sel   = ctrl.imm_sel;
                    o_alu_a_sel = ctrl.alu_a_sel;
                    o_alu_b_sel = ctrl.alu_b_sel;
                    o_wb_sel    = ctrl.wb_sel;
                    if (state == ST_MEM) begin
                        mem.o_dmem_req = 1'b1;
                        mem.o_dmem_we  = ctrl.is_store;
                    end
                    if (state == ST_WB) begin
                        o_pc_we  = 1'b1;
                        o_retire = 1'b1;
                        o_rf_we  = ctrl.rf_we;
                        o_pc_sel = ctrl.is_jump || (ctrl.is_branch && taken);
                    end
                end
`ifdef RV32I_ILLEGAL_TRAP_EN
                ST_TRAP: o_illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, max cycles waiting for a memory ack before bus error.
REQ-002 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_inst  input  32  instruction register contents, valid from DECODE onward.
REQ-005 SHALL have port i_imem_ack / i_dmem_ack  input  1 each  memory completion strobes.
REQ-006 SHALL have port o_imem_req / o_dmem_req / o_dmem_we  output  1 each  memory request and write enable.
REQ-007 SHALL have port o_ir_we, o_pc_we, o_rf_we  output  1 each  IR, PC and register-file write enables.
REQ-008 SHALL have port o_imm_sel  output  3  immediate format: I, S, B, U, J, NONE.
REQ-009 SHALL have port o_pc_sel (1), o_alu_a_sel (1), o_alu_b_sel (1), o_wb_sel (2)  output  datapath mux selects.
REQ-010 SHALL have port o_state  output  3  current FSM state; o_retire, o_bus_err  output  1  single-cycle pulses.

Function
REQ-011 SHALL sequence FETCH -> DECODE -> EXEC -> {MEM ->} WB -> FETCH; MEM only for LOAD/STORE.
REQ-012 FETCH SHALL hold o_imem_req=1 until i_imem_ack; on ack, pulse o_ir_we for that cycle and go to DECODE.
REQ-013 DECODE SHALL be exactly one cycle, driving o_imm_sel from i_inst[6:0]: OP-IMM/LOAD/JALR=I, STORE=S, BRANCH=B, LUI/AUIPC=U, JAL=J, else NONE.
REQ-014 o_imm_sel SHALL stay stable from DECODE through the last state of the instruction.
REQ-015 EXEC SHALL be one cycle; BRANCH, OP, OP-IMM, LUI, AUIPC, JAL, JALR go to WB; LOAD/STORE go to MEM.
REQ-016 MEM SHALL hold o_dmem_req=1 (o_dmem_we=1 for STORE only) until i_dmem_ack.
REQ-017 WB SHALL be one cycle: o_pc_we=1, o_retire=1, o_rf_we=1 except for BRANCH/STORE/illegal.
REQ-018 In WB, o_pc_sel SHALL select target for JAL/JALR and for BRANCH with i_inst-decoded condition flagged taken by the ALU path, else PC+4.
REQ-019 o_wb_sel SHALL be 0=ALU, 1=memory data (LOAD), 2=PC+4 (JAL/JALR).
REQ-020 A wait counter SHALL count cycles in FETCH/MEM without ack; reaching TIMEOUT_CYC SHALL pulse o_bus_err, drop the request and return to FETCH without retiring or writing.
REQ-021 Wait counter SHALL clear on every ack and every state change; ack on the timeout cycle SHALL win (no error).
REQ-022 Minimum latency: 4 cycles non-memory, 5 cycles LOAD/STORE with same-cycle acks.
REQ-023 Ack asserted outside its request state SHALL be ignored.

Reset
REQ-024 i_rst_n=0 at a clock edge SHALL force FETCH, counter=0, all enables/requests/pulses=0, selects=0, o_imm_sel=NONE.
REQ-025 Reset mid-MEM SHALL abort the access with no write-back and no o_retire.
REQ-026 First request SHALL be asserted in the first cycle after i_rst_n returns high.

Configuration
REQ-027 With RV32I_ILLEGAL_TRAP_EN defined, an unknown opcode in DECODE SHALL go to state TRAP, assert o_illegal (extra 1-bit output) and hold until reset.
REQ-028 Without RV32I_ILLEGAL_TRAP_EN, unknown opcodes SHALL execute as NOP (EXEC -> WB, PC+4, no RF write, o_retire=1) and o_illegal SHALL not exist.

Structure
REQ-029 Opcode constants, the state enum and the imm_sel enum SHALL live in a shared package also used by the immediate generator.
REQ-030 Opcode-to-control decode SHALL be one combinational sub-module, ctrl_decode; FSM and counter stay in multicycle_ctrl.

Verification
REQ-031 ADDI (0x00500093), acks same cycle -> states F,D,E,W; o_imm_sel=I; o_rf_we and o_retire in cycle 4.
REQ-032 SW (0x00112223), dmem ack after 3 cycles -> o_dmem_we=1 for 4 MEM cycles, o_rf_we=0, retire in cycle 8.
REQ-033 No imem ack for 16 cycles -> o_bus_err pulse cycle 16, req drops, FETCH re-entered, no retire.
REQ-034 Reset low during MEM of LW (0x0000A103) -> next cycle FETCH, o_rf_we/o_retire never asserted.
REQ-035 Opcode 0x7F -> with macro: TRAP, o_illegal=1 held; without: PC+4 retire, o_rf_we=0.
REQ-036 JAL (0x008000EF) -> o_imm_sel=J, o_wb_sel=2, o_pc_sel=target in WB.
